// File: rtl/signmag_pkg.sv
// Shared constants, types and the reference encoding for the sign-magnitude
// encoder. Used by signmag_negate and signmag_encoder.
package signmag_pkg;

  localparam int SMAG_DATA_W = 8;

  // Most negative two's-complement value; it has no sign-magnitude twin.
  localparam logic [SMAG_DATA_W-1:0] MOST_NEG = {1'b1, {(SMAG_DATA_W-1){1'b0}}};

  // Largest representable magnitude, used when MOST_NEG must be clamped.
  localparam logic [SMAG_DATA_W-2:0] SAT_MAG = '1;

  localparam logic [SMAG_DATA_W-2:0] SMAG_MAG_ONE = 1;

  typedef struct packed {
    logic                   sat;
    logic [SMAG_DATA_W-1:0] word;
  } sm_word_t;

  // Two's-complement to sign-magnitude for the default width.
  // MOST_NEG clamps to -(2^(W-1)-1) and raises sat, so negative zero never appears.
  function automatic sm_word_t tc_to_sm(input logic [SMAG_DATA_W-1:0] tc);
    sm_word_t r;
    r.sat = (tc == MOST_NEG);
    if (!tc[SMAG_DATA_W-1]) begin
      r.word = tc;
    end else if (r.sat) begin
      r.word = {1'b1, SAT_MAG};
    end else begin
      r.word = {1'b1, (~tc[SMAG_DATA_W-2:0]) + SMAG_MAG_ONE};
    end
    return r;
  endfunction

endpackage

// File: rtl/signmag_negate.sv
// Combinational two's-complement -> sign-magnitude conversion with saturation
// of the most negative input. The default width reuses the package function;
// other widths use the equivalent generic logic.
module signmag_negate
  import signmag_pkg::*;
#(
  parameter int DATA_W = SMAG_DATA_W
) (
  input  logic [DATA_W-1:0] tc,
  output logic [DATA_W-1:0] sm,
  output logic              sat
);

  generate
    if (DATA_W == SMAG_DATA_W) begin : g_pkg
      sm_word_t r;

      assign r   = tc_to_sm(tc);
      assign sm  = r.word;
      assign sat = r.sat;
    end else begin : g_generic
      localparam logic [DATA_W-2:0] MAG_ONE = 1;

      logic is_min;

      assign is_min = (tc == {1'b1, {(DATA_W-1){1'b0}}});

      // Negate the low bits only: the sign of the result is forced separately.
      always_comb begin
        sm  = tc;
        sat = 1'b0;
        if (tc[DATA_W-1]) begin
          if (is_min) begin
            sm  = {1'b1, {(DATA_W-1){1'b1}}};
            sat = 1'b1;
          end else begin
            sm = {1'b1, (~tc[DATA_W-2:0]) + MAG_ONE};
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/signmag_encoder.sv
// Streaming two's-complement -> sign-magnitude encoder.
// Two registered stages (encode register, output register) with valid/ready on
// both sides and full throughput. Optional saturation counter is enabled by
// defining SMAG_SAT_CNT_EN, which adds the sat_count port.
module signmag_encoder
  import signmag_pkg::*;
#(
  parameter int DATA_W = SMAG_DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] DataIn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] DataOut,
  output logic              out_sat
`ifdef SMAG_SAT_CNT_EN
  ,
  output logic [CNT_W-1:0]  sat_count
`endif
);

  generate
    if (DATA_W < 2 || CNT_W < 1) begin : g_bad_param
      $error("signmag_encoder: DATA_W must be >= 2 and CNT_W >= 1");
    end
  endgenerate

  logic              s1_valid;
  logic [DATA_W-1:0] s1_word;
  logic              s1_sat;

  logic [DATA_W-1:0] enc_word;
  logic              enc_sat;

  logic              s2_load;
  logic              s1_advance;
  logic              in_xfer;

  signmag_negate #(
    .DATA_W (DATA_W)
  ) u_negate (
    .tc  (DataIn),
    .sm  (enc_word),
    .sat (enc_sat)
  );

  // Output stage may take a new word when empty or when its word leaves now.
  assign s2_load    = !out_valid | out_ready;
  assign s1_advance = s1_valid & s2_load;
  // Held low during reset so nothing is accepted into a stage being cleared.
  assign in_ready   = !rst & (!s1_valid | s1_advance);
  assign in_xfer    = in_valid & in_ready;

  // Stage 1: capture the encoded input word and its saturation flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
      s1_sat   <= 1'b0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_word  <= enc_word;
      s1_sat   <= enc_sat;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: output register; holds its word while the sink stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      DataOut   <= '0;
      out_sat   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        DataOut <= s1_word;
        out_sat <= s1_sat;
      end
    end
  end

`ifdef SMAG_SAT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic out_xfer;

  assign out_xfer = out_valid & out_ready;

  // Count saturated words as they leave; stick at full scale instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count <= '0;
    end else if (out_xfer && out_sat && (sat_count != '1)) begin
      sat_count <= sat_count + CNT_ONE;
    end
  end
`endif

endmodule
